// File: rtl/int_to_fp_sched_pkg.sv
// Shared FPU scheduling definitions: default widths, scheduler state encoding,
// and a constant-evaluable clog2 used to size pointers and counters.
package int_to_fp_sched_pkg;

  localparam int DEF_INT_SIZE      = 32;
  localparam int DEF_PRECISION     = 32;
  localparam int DEF_EXPONENT_SIZE = 8;
  localparam int DEF_MANTISSA_SIZE = 23;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/int_to_fp_sched_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping around; grant is one-hot, or zero when nothing is requesting.
module rr_pick #(
  parameter int num_req = 4,
  parameter int ptr_w   = 2
) (
  input  logic [num_req-1:0] req,
  input  logic [ptr_w-1:0]   ptr,
  output logic [num_req-1:0] grant
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < num_req; i++) begin
      for (int k = 0; k < num_req; k++) begin
        if (!found && req[k] && (((int'(ptr) + i) % num_req) == k)) begin
          grant[k] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/int_to_fp_sched.sv
// Shares one registered int-to-float converter among num_req requesters:
// grant round-robin, wait out the converter latency, strobe the result back.
module int_to_fp_sched
  import int_to_fp_sched_pkg::*;
#(
  parameter int num_req      = 4,
  parameter int int_size     = DEF_INT_SIZE,
  parameter int precision    = DEF_PRECISION,
  parameter int conv_latency = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [num_req-1:0]          req_valid,
  input  logic [num_req*int_size-1:0] req_int,
  output logic [num_req-1:0]          req_ready,
  output logic [int_size-1:0]         conv_int,
  input  logic [precision-1:0]        conv_fp,
  output logic [num_req-1:0]          rsp_valid,
  output logic [precision-1:0]        rsp_fp,
  output logic                        busy
);

  localparam int id_w  = (clog2(num_req) < 1) ? 1 : clog2(num_req);
  localparam int cnt_w = (clog2(conv_latency + 1) < 1) ? 1 : clog2(conv_latency + 1);

  state_t                state;
  logic [id_w-1:0]       rr_ptr;
  logic [id_w-1:0]       id_reg;
  logic [cnt_w-1:0]      cnt;
  logic [int_size-1:0]   op_reg;
  logic [num_req-1:0]    grant;
  logic [id_w-1:0]       win;
  logic [int_size-1:0]   win_int;
  logic                  xfer;

  rr_pick #(
    .num_req (num_req),
    .ptr_w   (id_w)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Handshake: requester k holds req_valid[k] and a stable operand; a transfer
  // happens on the rising edge where req_valid[k] & req_ready[k]. Grants are
  // only offered in IDLE and are held low while reset is asserted.
  assign req_ready = (state == ST_IDLE && reset) ? grant : '0;
  assign xfer      = |(req_valid & req_ready);
  assign conv_int  = op_reg;
  assign busy      = (state == ST_WAIT);

  always_comb begin
    win     = '0;
    win_int = '0;
    for (int k = 0; k < num_req; k++) begin
      if (grant[k]) begin
        win     = id_w'(k);
        win_int = req_int[k*int_size +: int_size];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      id_reg    <= '0;
      cnt       <= '0;
      op_reg    <= '0;
      rsp_valid <= '0;
      rsp_fp    <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            op_reg <= win_int;
            id_reg <= win;
            cnt    <= cnt_w'(conv_latency);
            rr_ptr <= (win == id_w'(num_req - 1)) ? '0 : win + 1'b1;
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // One extra edge beyond conv_latency lets the converter output settle
          // before capture, so the strobe lands on the first IDLE cycle.
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_fp    <= conv_fp;
            rsp_valid <= num_req'(1) << id_reg;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
